// File: rtl/adder_arbiter_if.sv
// Requester handshake plus the operand/result bus of the shared adder used by adder_arbiter.
// The master side hosts the requesters and the combinational adder itself.
interface adder_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_carry;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic [WIDTH-1:0]       add_c;

  modport master (
    output req, req_a, req_b, rsp_ready, add_c,
    input  gnt, rsp_valid, rsp_data, rsp_carry, add_a, add_b
  );

  modport slave (
    input  req, req_a, req_b, rsp_ready, add_c,
    output gnt, rsp_valid, rsp_data, rsp_carry, add_a, add_b
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder between N_REQ requesters:
// IDLE grants and latches operands, EXEC captures sum and carry, RESP holds the result until consumed.
module adder_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic [IW-1:0]    last_r;
  logic [IW-1:0]    win_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_carry_r;
  logic [N_REQ-1:0] rsp_valid_r;

  logic [IW-1:0]    pick_s;
  logic [N_REQ-1:0] gnt_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

  // First requester after 'last' in ascending order with wrap; descending scan so the nearest wins.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    sel = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (r[idx]) begin
        sel = idx;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Winner selection and operand mux; gnt is the IDLE-cycle decode so the requester can drop req at the latching edge.
  always_comb begin
    pick_s  = rr_pick(bus.req, last_r);
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_s == IW'(i)) begin
        sel_a_s = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_s = bus.req_b[i*WIDTH +: WIDTH];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
    if (rst_n && (state_r == IDLE) && (bus.req != '0)) begin
      gnt_s = N_REQ'(1'b1) << pick_s;
    end else begin
      gnt_s = '0;
    end
  end

  // Control FSM with registered operands and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_r      <= IW'(N_REQ - 1);
      win_r       <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      rsp_data_r  <= '0;
      rsp_carry_r <= 1'b0;
      rsp_valid_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req != '0) begin
            last_r  <= pick_s;
            win_r   <= pick_s;
            op_a_r  <= sel_a_s;
            op_b_r  <= sel_b_s;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          // A wrapped sum is always smaller than either operand.
          rsp_data_r  <= bus.add_c;
          rsp_carry_r <= (bus.add_c < op_a_r);
          rsp_valid_r <= N_REQ'(1'b1) << win_r;
          state_r     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[win_r]) begin
            rsp_valid_r <= '0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_carry = rsp_carry_r;
  assign bus.add_a     = op_a_r;
  assign bus.add_b     = op_b_r;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: randomized and directed requesters, a transaction-level reference model
// and a response scoreboard checked by an independent monitor.
module tb_adder_arbiter;
  localparam int W  = 8;
  localparam int N  = 3;
  localparam int IW = 2;

  typedef struct {
    int           idx;
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [N-1:0] gnt_last;
  logic [N-1:0] keep;

  always #5 clk = ~clk;

  adder_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();
  assign bus.add_c = bus.add_a + bus.add_b;

  adder_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor and reference model, sampled mid-cycle once inputs have settled.
  initial begin : monitor
    bit           m_busy = 1'b0;
    int           m_owner = 0;
    int           m_gcyc = 0;
    int           m_last = N - 1;
    int           w;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    logic [W:0]   s9;
    exp_t         e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
        chk("rst_add_a", 32'(bus.add_a), 32'd0);
        chk("rst_add_b", 32'(bus.add_b), 32'd0);
        m_busy = 1'b0;
        m_last = N - 1;
        exp_q.delete();
      end else begin
        exp_gnt = '0;
        exp_rv  = '0;
        if (!m_busy && bus.req != '0) begin
          w = -1;
          for (int k = 1; k <= N; k++) begin
            if (w < 0 && bus.req[IW'((m_last + k) % N)]) w = (m_last + k) % N;
          end
          exp_gnt = 3'b001 << w;
          s9 = {1'b0, bus.req_a[w*W +: W]} + {1'b0, bus.req_b[w*W +: W]};
          e.idx = w;
          e.sum = s9[W-1:0];
          e.carry = s9[W];
          exp_q.push_back(e);
          m_busy  = 1'b1;
          m_owner = w;
          m_gcyc  = cyc;
          m_last  = w;
        end else if (m_busy && cyc >= m_gcyc + 2) begin
          exp_rv = 3'b001 << m_owner;
          if (bus.rsp_ready[IW'(m_owner)]) m_busy = 1'b0;
        end
        chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (bus.rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
          end else begin
            e = exp_q[0];
            chk("rsp_owner", 32'(bus.rsp_valid), 32'(3'b001 << e.idx));
            chk("rsp_data", 32'(bus.rsp_data), 32'(e.sum));
            chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.carry));
            if ((bus.rsp_valid & bus.rsp_ready) != '0) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Advance one cycle (called and returning at +2 after the rising edge); granted requesters retire or reload.
  task automatic cycle();
    #6;
    gnt_last = bus.gnt;
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (gnt_last[IW'(i)]) begin
        if (keep[IW'(i)]) begin
          bus.req_a[i*W +: W] = W'($urandom);
          bus.req_b[i*W +: W] = W'($urandom);
        end else begin
          bus.req[IW'(i)] = 1'b0;
        end
      end
    end
  endtask

  task automatic put(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req[IW'(i)]     = 1'b1;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  initial begin
    rst_n         = 1'b0;
    keep          = '0;
    bus.req       = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    @(posedge clk);
    #2;
    cycle();
    rst_n = 1'b1;

    // single request, then overflow
    bus.rsp_ready = 3'b111;
    put(0, 8'h12, 8'h34);
    repeat (5) cycle();
    put(1, 8'hFF, 8'h02);
    repeat (5) cycle();

    // contention from a fresh reset: order 0,1,2,0 every 3 cycles
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    keep = 3'b111;
    for (int i = 0; i < N; i++) put(i, W'($urandom), W'($urandom));
    repeat (13) cycle();
    keep = '0;
    repeat (10) cycle();

    // backpressure with competing requests and ready only on non-winners
    bus.rsp_ready = 3'b000;
    put(0, 8'h80, 8'h80);
    cycle();
    put(1, 8'h01, 8'h02);
    put(2, 8'h03, 8'h04);
    repeat (6) cycle();
    bus.rsp_ready = 3'b110;
    repeat (2) cycle();
    bus.rsp_ready = 3'b111;
    repeat (10) cycle();

    // reset during EXEC, then rotation restarts from requester 0
    put(0, 8'h55, 8'h66);
    cycle();
    rst_n   = 1'b0;
    bus.req = '0;
    cycle();
    rst_n = 1'b1;
    put(2, 8'h10, 8'h20);
    repeat (4) cycle();
    put(0, 8'hAA, 8'hBB);
    cycle();
    rst_n   = 1'b0;
    bus.req = '0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) put(i, W'($urandom), W'($urandom));
    repeat (12) cycle();

    // withdrawal: requester 2 pulses req for one RESP cycle only
    bus.rsp_ready = 3'b000;
    put(0, 8'h01, 8'h01);
    repeat (2) cycle();
    put(2, 8'h77, 8'h77);
    cycle();
    bus.req[2] = 1'b0;
    repeat (3) cycle();
    bus.rsp_ready = 3'b111;
    repeat (5) cycle();

    // random traffic with withdrawals, backpressure and occasional resets
    for (int t = 0; t < 400; t++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      bus.rsp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!bus.req[IW'(i)] && $urandom_range(0, 3) == 0) begin
          put(i, W'($urandom), W'($urandom));
        end else if (bus.req[IW'(i)] && $urandom_range(0, 15) == 0) begin
          bus.req[IW'(i)] = 1'b0;
        end
      end
      cycle();
    end

    rst_n         = 1'b1;
    bus.req       = '0;
    bus.rsp_ready = 3'b111;
    repeat (6) cycle();
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter N_REQ, default 3, number of requesters sharing the adder.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N_REQ  per-requester add request; bit i belongs to requester i.
REQ-007 req_a  input  N_REQ*WIDTH  operand A; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 req_b  input  N_REQ*WIDTH  operand B, same slicing as req_a.
REQ-009 gnt  output  N_REQ  one-hot, one-cycle acceptance pulse.
REQ-010 rsp_valid  output  N_REQ  one-hot; result available for requester i.
REQ-011 rsp_ready  input  N_REQ  requester i consumes its result.
REQ-012 rsp_data  output  WIDTH  registered sum for the requester flagged in rsp_valid.
REQ-013 rsp_carry  output  1  unsigned carry-out of that sum.
REQ-014 add_a  output  WIDTH  operand A driven to the shared adder instance.
REQ-015 add_b  output  WIDTH  operand B driven to the shared adder instance.
REQ-016 add_c  input  WIDTH  combinational sum returned by the shared adder (modulo 2^WIDTH).

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-018 IDLE: if any req bit set, SHALL select winner by round-robin, assert gnt for winner that cycle, latch winner's req_a/req_b into operand registers and winner index, go to EXEC; else stay IDLE, gnt=0.
REQ-019 Round-robin: search starts at index (last_winner+1) mod N_REQ, ascending with wrap; last_winner updates only on a grant.
REQ-020 add_a/add_b SHALL be driven solely from the operand registers (never directly from req_a/req_b).
REQ-021 EXEC: SHALL capture add_c into rsp_data and carry into rsp_carry, go to RESP; lasts exactly one cycle.
REQ-022 Carry SHALL be computed as (add_c < add_a) unsigned, using the registered operand.
REQ-023 RESP: rsp_valid SHALL be one-hot at winner index; rsp_data/rsp_carry SHALL hold stable.
REQ-024 RESP: when rsp_ready[winner]=1, SHALL clear rsp_valid and return to IDLE next cycle; rsp_ready on non-winner bits SHALL be ignored.
REQ-025 rsp_ready asserted in the first RESP cycle SHALL complete the response in that cycle (one-cycle RESP).
REQ-026 Latency: grant at cycle N (IDLE), EXEC at N+1, rsp_valid high from N+2; minimum issue interval 3 cycles.
REQ-027 Requests arriving in EXEC/RESP SHALL NOT be granted; a requester holds req and operands until it sees gnt.
REQ-028 req deasserted before grant SHALL be treated as withdrawn; no gnt issued for it.
REQ-029 A winner that re-asserts req in the same cycle it is serviced SHALL be queued behind other pending requesters per REQ-019.
REQ-030 Overflow SHALL wrap modulo 2^WIDTH in rsp_data with rsp_carry=1; no other flag.
REQ-031 gnt and rsp_valid SHALL each never have more than one bit set.

Reset
REQ-032 On rst_n=0, SHALL immediately (asynchronously) force state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_carry=0, operand registers=0 (add_a=add_b=0), last_winner=N_REQ-1 (so requester 0 wins first).
REQ-033 Reset during EXEC or RESP SHALL abort the operation; no rsp_valid after release for the aborted request.
REQ-034 First grant possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-035 Single request: req=001, a0=8'h12, b0=8'h34 -> gnt=001 at N, rsp_valid=001 at N+2, rsp_data=8'h46, rsp_carry=0.
REQ-036 Overflow: a1=8'hFF, b1=8'h02 -> rsp_data=8'h01, rsp_carry=1, rsp_valid=010.
REQ-037 Contention: req=111 held, rsp_ready=111 always -> grant order 001,010,100,001, grants spaced exactly 3 cycles.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, no new gnt despite other req bits; release -> IDLE next cycle.
REQ-039 Reset mid-op: assert rst_n=0 during EXEC -> all outputs 0 immediately; after release with req=100 -> gnt=100 (rotation not stale) only if 001/010 idle; with req=111 -> gnt=001.
REQ-040 Withdrawal: req[2] pulsed for one cycle while in RESP -> never granted, no rsp_valid[2].
